// File: rtl/fir_ss_ingress.sv
// fir_ss_ingress: input conditioning ahead of the FIR ss_* AXI-Stream port.
// Buffers upstream samples in a show-ahead FIFO and admits exactly cfg_len
// samples per run. m_tlast is generated locally on sample cfg_len-1, and
// upstream tlast mismatches raise a sticky error flag.
//
// Ports:
//   axis_clk, axis_rst_n        clock, async active-low reset
//   cfg_start, cfg_len          run start pulse and run length
//   s_tvalid/tdata/tlast/tready upstream AXI-Stream (tlast only checked)
//   m_tvalid/tdata/tlast/tready downstream AXI-Stream to the FIR
//   busy, done, err_tlast       status: running, end-of-run pulse, tlast error
//   level                       FIFO occupancy 0..DEPTH
//
// Build option FIR_INGRESS_ZPAD_EN: an early upstream tlast stops intake and
// the run is completed with zero samples so the FIR still gets cfg_len.
module fir_ss_ingress #(
    parameter int pDATA_WIDTH = 32,
    parameter int pFIFO_AW    = 3
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   cfg_start,
    input  logic [31:0]            cfg_len,
    input  logic                   s_tvalid,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic                   m_tvalid,
    output logic [pDATA_WIDTH-1:0] m_tdata,
    output logic                   m_tlast,
    input  logic                   m_tready,
    output logic                   busy,
    output logic                   done,
    output logic                   err_tlast,
    output logic [pFIFO_AW:0]      level
);

    localparam int DEPTH = 2 ** pFIFO_AW;
    localparam logic [pFIFO_AW:0] LVL_FULL = (pFIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_PAD   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [pDATA_WIDTH-1:0] mem_q [DEPTH];

    logic [pFIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [pFIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [pFIFO_AW:0]   level_q, level_d;
    logic [31:0]         in_cnt_q, in_cnt_d;
    logic [31:0]         out_cnt_q, out_cnt_d;
    logic [31:0]         len_q, len_d;
    logic                err_q, err_d;
    logic                done_q, done_d;

    logic                   s_tready_o;
    logic                   busy_o;
    logic                   pad_mode;
    logic                   not_full;
    logic                   push;
    logic                   pad_wr;
    logic                   wr_en;
    logic                   pop;
    logic                   last_in;
    logic                   last_pop;
    logic                   start_idle;
    logic [pDATA_WIDTH-1:0] wr_data;

    // ------------------------------------------------------------------
    // Handshake and FIFO control
    // ------------------------------------------------------------------
    assign not_full   = (level_q != LVL_FULL);
    assign m_tvalid   = (level_q != '0);
    // Gate the head so an empty FIFO shows zero rather than stale memory.
    assign m_tdata    = m_tvalid ? mem_q[rd_ptr_q] : '0;
    assign m_tlast    = m_tvalid & (out_cnt_q == len_q - 32'd1);
    assign push       = s_tvalid & s_tready_o;
    assign pop        = m_tvalid & m_tready;
    assign last_in    = (in_cnt_q == len_q - 32'd1);
    assign last_pop   = pop & m_tlast;
    assign start_idle = cfg_start & (state_q == ST_IDLE);

`ifdef FIR_INGRESS_ZPAD_EN
    // Padding writes a zero sample per cycle while there is room.
    assign pad_wr  = pad_mode & not_full;
    assign wr_data = pad_wr ? '0 : s_tdata;
`else
    assign pad_wr  = 1'b0;
    assign wr_data = s_tdata;
`endif

    assign wr_en = push | pad_wr;

    assign s_tready  = s_tready_o;
    assign busy      = busy_o;
    assign done      = done_q;
    assign err_tlast = err_q;
    assign level     = level_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_start && (cfg_len != 32'd0)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (push) begin
                    if (last_in) begin
                        state_d = ST_DRAIN;
                    end
`ifdef FIR_INGRESS_ZPAD_EN
                    else if (s_tlast) begin
                        state_d = ST_PAD;
                    end
`endif
                end
            end
            ST_PAD: begin
                if (wr_en && last_in) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_pop) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        s_tready_o = 1'b0;
        busy_o     = 1'b0;
        pad_mode   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
            end
            ST_RUN: begin
                busy_o     = 1'b1;
                s_tready_o = not_full & (in_cnt_q < len_q);
            end
            ST_PAD: begin
                busy_o   = 1'b1;
                pad_mode = 1'b1;
            end
            ST_DRAIN: begin
                busy_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        len_d     = len_q;
        err_d     = err_q;
        done_d    = 1'b0;

        if (start_idle) begin
            err_d = 1'b0;
            if (cfg_len != 32'd0) begin
                len_d     = cfg_len;
                in_cnt_d  = 32'd0;
                out_cnt_d = 32'd0;
            end else begin
                done_d = 1'b1;
            end
        end

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            in_cnt_d = in_cnt_q + 32'd1;
        end

        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            out_cnt_d = out_cnt_q + 32'd1;
        end

        unique case ({wr_en, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // tlast must be high on exactly the final sample of the run.
        if (push && (s_tlast != last_in)) begin
            err_d = 1'b1;
        end

        if ((state_q == ST_DRAIN) && last_pop) begin
            done_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            len_q     <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            len_q     <= len_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    // Storage needs no reset: level_q gates every read.
    always_ff @(posedge axis_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_fir_ss_ingress.sv
// tb_fir_ss_ingress: directed self-checking bench for fir_ss_ingress.
// Per-cycle vector table for a basic run, then multi-cycle sequences.
module tb_fir_ss_ingress;

    logic        axis_clk;
    logic        axis_rst_n;
    logic        cfg_start;
    logic [31:0] cfg_len;
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        s_tready;
    logic        m_tvalid;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        m_tready;
    logic        busy;
    logic        done;
    logic        err_tlast;
    logic [3:0]  level;

    fir_ss_ingress #(.pDATA_WIDTH(32), .pFIFO_AW(3)) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .cfg_start  (cfg_start),
        .cfg_len    (cfg_len),
        .s_tvalid   (s_tvalid),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tvalid   (m_tvalid),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .busy       (busy),
        .done       (done),
        .err_tlast  (err_tlast),
        .level      (level)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        st;
        logic [31:0] len;
        logic        sv;
        logic [31:0] sd;
        logic        sl;
        logic        mr;
        logic        e_srdy;
        logic        e_mv;
        logic [31:0] e_md;
        logic        e_ml;
        logic        e_busy;
        logic        e_done;
        logic        e_err;
        logic [3:0]  e_lvl;
    } vec_t;

    vec_t tv[9];

    logic [31:0] src_d[$];
    logic        src_l[$];
    logic [31:0] out_d[$];
    logic        out_l[$];
    logic [31:0] exp_d[$];
    int          max_lvl;
    int          stable_bad;
    int          full_rdy_bad;
    logic        saw_done;

    task automatic start_run(input logic [31:0] len);
        @(negedge axis_clk);
        cfg_start = 1'b1;
        cfg_len   = len;
        @(negedge axis_clk);
        cfg_start = 1'b0;
    endtask

    // Drives src_* as a source, m_tready low for the first 'stall'
    // cycles, and collects popped beats until done or budget expiry.
    task automatic stream(input string nm, input int stall,
                          input int budget);
        int          si;
        int          cyc;
        logic        hv;
        logic [31:0] held;
        si = 0;
        cyc = 0;
        hv = 1'b0;
        held = '0;
        out_d.delete();
        out_l.delete();
        max_lvl = 0;
        stable_bad = 0;
        full_rdy_bad = 0;
        saw_done = 1'b0;
        while (!saw_done && cyc < budget) begin
            s_tvalid = (si < src_d.size());
            s_tdata  = s_tvalid ? src_d[si] : '0;
            s_tlast  = s_tvalid ? src_l[si] : 1'b0;
            m_tready = (cyc >= stall);
            #1;
            if (done) saw_done = 1'b1;
            if (int'(level) > max_lvl) max_lvl = int'(level);
            if (level == 4'd8 && s_tready) full_rdy_bad++;
            if (hv && m_tvalid && m_tdata !== held) stable_bad++;
            hv   = m_tvalid & ~m_tready;
            held = m_tdata;
            if (m_tvalid && m_tready) begin
                out_d.push_back(m_tdata);
                out_l.push_back(m_tlast);
            end
            if (s_tvalid && s_tready) si++;
            @(negedge axis_clk);
            cyc++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        chk({nm, " done_seen"}, 32'(saw_done), 32'd1);
    endtask

    task automatic check_out(input string nm);
        chk({nm, " out_count"}, out_d.size(), exp_d.size());
        for (int i = 0; i < out_d.size() && i < exp_d.size(); i++) begin
            chk($sformatf("%s data[%0d]", nm, i), out_d[i], exp_d[i]);
            chk($sformatf("%s tlast[%0d]", nm, i), 32'(out_l[i]),
                32'(i == exp_d.size() - 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0] = '{1'b1, 32'd5, 1'b0, 32'd0, 1'b0, 1'b0,
                  1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tv[1] = '{1'b0, 32'd0, 1'b1, 32'd1, 1'b0, 1'b1,
                  1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        tv[2] = '{1'b0, 32'd0, 1'b1, 32'd2, 1'b0, 1'b1,
                  1'b1, 1'b1, 32'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
        tv[3] = '{1'b0, 32'd0, 1'b1, 32'd3, 1'b0, 1'b1,
                  1'b1, 1'b1, 32'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
        tv[4] = '{1'b0, 32'd0, 1'b1, 32'd4, 1'b0, 1'b1,
                  1'b1, 1'b1, 32'd3, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
        tv[5] = '{1'b0, 32'd0, 1'b1, 32'd5, 1'b1, 1'b1,
                  1'b1, 1'b1, 32'd4, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
        tv[6] = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1,
                  1'b0, 1'b1, 32'd5, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1};
        tv[7] = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1,
                  1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        tv[8] = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1,
                  1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};

        axis_rst_n = 1'b0;
        cfg_start  = 1'b0;
        cfg_len    = '0;
        s_tvalid   = 1'b0;
        s_tdata    = '0;
        s_tlast    = 1'b0;
        m_tready   = 1'b0;

        #1;
        chk("rst s_tready", 32'(s_tready), 32'd0);
        chk("rst m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst m_tdata", m_tdata, 32'd0);
        chk("rst m_tlast", 32'(m_tlast), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst err", 32'(err_tlast), 32'd0);
        chk("rst level", 32'(level), 32'd0);
        @(negedge axis_clk);
        @(negedge axis_clk);
        axis_rst_n = 1'b1;

        // T1: cycle-exact table, len=5, data 1..5
        for (int i = 0; i < 9; i++) begin
            @(negedge axis_clk);
            cfg_start = tv[i].st;
            cfg_len   = tv[i].len;
            s_tvalid  = tv[i].sv;
            s_tdata   = tv[i].sd;
            s_tlast   = tv[i].sl;
            m_tready  = tv[i].mr;
            #1;
            chk($sformatf("t1[%0d] s_tready", i), 32'(s_tready), 32'(tv[i].e_srdy));
            chk($sformatf("t1[%0d] m_tvalid", i), 32'(m_tvalid), 32'(tv[i].e_mv));
            chk($sformatf("t1[%0d] m_tdata", i), m_tdata, tv[i].e_md);
            chk($sformatf("t1[%0d] m_tlast", i), 32'(m_tlast), 32'(tv[i].e_ml));
            chk($sformatf("t1[%0d] busy", i), 32'(busy), 32'(tv[i].e_busy));
            chk($sformatf("t1[%0d] done", i), 32'(done), 32'(tv[i].e_done));
            chk($sformatf("t1[%0d] err", i), 32'(err_tlast), 32'(tv[i].e_err));
            chk($sformatf("t1[%0d] level", i), 32'(level), 32'(tv[i].e_lvl));
        end
        cfg_start = 1'b0;
        s_tvalid  = 1'b0;
        m_tready  = 1'b0;

        // T2: len=12, downstream stalled 20 cycles
        src_d.delete(); src_l.delete(); exp_d.delete();
        for (int i = 0; i < 12; i++) begin
            src_d.push_back(32'(100 + i));
            src_l.push_back(i == 11);
            exp_d.push_back(32'(100 + i));
        end
        start_run(32'd12);
        stream("t2", 20, 200);
        check_out("t2");
        chk("t2 max_level", max_lvl, 8);
        chk("t2 ready_on_full", full_rdy_bad, 0);
        chk("t2 head_stable", stable_bad, 0);
        chk("t2 err", 32'(err_tlast), 32'd0);

        // T3: len=4, early tlast on sample 2
        src_d.delete(); src_l.delete(); exp_d.delete();
        src_d = '{32'd7, 32'd8, 32'd9, 32'd10};
        src_l = '{1'b0, 1'b1, 1'b0, 1'b1};
`ifdef FIR_INGRESS_ZPAD_EN
        exp_d = '{32'd7, 32'd8, 32'd0, 32'd0};
`else
        exp_d = '{32'd7, 32'd8, 32'd9, 32'd10};
`endif
        start_run(32'd4);
        stream("t3", 0, 100);
        check_out("t3");
        chk("t3 err", 32'(err_tlast), 32'd1);

        // T4: len=3, tlast never asserted
        src_d.delete(); src_l.delete(); exp_d.delete();
        src_d = '{32'h11, 32'h22, 32'h33};
        src_l = '{1'b0, 1'b0, 1'b0};
        exp_d = '{32'h11, 32'h22, 32'h33};
        start_run(32'd3);
        #1;
        chk("t4 err_cleared", 32'(err_tlast), 32'd0);
        stream("t4", 0, 100);
        check_out("t4");
        chk("t4 err", 32'(err_tlast), 32'd1);

        // T5a: zero-length start
        @(negedge axis_clk);
        cfg_start = 1'b1;
        cfg_len   = 32'd0;
        #1;
        chk("t5 busy_at_start", 32'(busy), 32'd0);
        @(negedge axis_clk);
        cfg_start = 1'b0;
        #1;
        chk("t5 done_pulse", 32'(done), 32'd1);
        chk("t5 busy", 32'(busy), 32'd0);
        @(negedge axis_clk);
        #1;
        chk("t5 done_gone", 32'(done), 32'd0);

        // T5b: cfg_start during RUN is ignored
        src_d.delete(); src_l.delete(); exp_d.delete();
        src_d = '{32'h5a, 32'h5b, 32'h5c};
        src_l = '{1'b0, 1'b0, 1'b1};
        exp_d = '{32'h5a, 32'h5b, 32'h5c};
        @(negedge axis_clk);
        start_run(32'd3);
        cfg_start = 1'b1;
        cfg_len   = 32'd9;
        #1;
        chk("t5b busy", 32'(busy), 32'd1);
        @(negedge axis_clk);
        cfg_start = 1'b0;
        stream("t5b", 0, 100);
        check_out("t5b");
        chk("t5b err", 32'(err_tlast), 32'd0);

        // T6: reset mid-run with level=5
        start_run(32'd8);
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'(200 + i);
            s_tlast  = 1'b0;
            @(negedge axis_clk);
        end
        s_tvalid = 1'b0;
        #1;
        chk("t6 level_pre", 32'(level), 32'd5);
        axis_rst_n = 1'b0;
        #1;
        chk("t6 level", 32'(level), 32'd0);
        chk("t6 m_tvalid", 32'(m_tvalid), 32'd0);
        chk("t6 busy", 32'(busy), 32'd0);
        chk("t6 s_tready", 32'(s_tready), 32'd0);
        @(negedge axis_clk);
        axis_rst_n = 1'b1;
        src_d.delete(); src_l.delete(); exp_d.delete();
        src_d = '{32'hab, 32'hcd};
        src_l = '{1'b0, 1'b1};
        exp_d = '{32'hab, 32'hcd};
        start_run(32'd2);
        stream("t6", 0, 100);
        check_out("t6");
        chk("t6 err", 32'(err_tlast), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
